// File: rtl/blink_pkg.sv
// Shared types and defaults for the LED blink sequencer.
// Feature macro used by the top: BLINK_STATS_EN (wrap counter).
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN
    } blink_state_t;

    localparam int         DEFAULT_PATTERN_LEN = 8;
    localparam logic [7:0] DEFAULT_PATTERN     = 8'b1010_1100;

endpackage

// File: rtl/edge_sync_detect.sv
// Purpose: synchronise a slow level and emit a one-cycle pulse on each rising edge.
// Latency: rise is seen SYNC_STAGES cycles after the level is first sampled high.
// Backpressure: none; free-running, pulses are masked until the chain has primed after reset.
module edge_sync_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    localparam int                 PRIME_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [PRIME_W-1:0] PRIME_INIT = PRIME_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_sync;
    logic                   s_prev;
    logic [PRIME_W-1:0]     prime_cnt;
    logic                   primed;

    assign s_sync = sync_q[SYNC_STAGES-1];
    assign primed = (prime_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            s_prev    <= 1'b0;
            prime_cnt <= PRIME_INIT;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            s_prev <= s_sync;
            // Hold off until s_prev holds a genuine post-reset sample, so a
            // level that was already high across reset never fakes an edge.
            if (!primed) begin
                prime_cnt <= prime_cnt - 1'b1;
            end
        end
    end

    assign rise = s_sync & ~s_prev & primed;

endmodule

// File: rtl/blink_sequencer.sv
// Purpose: play a programmable LED pattern, one bit per divided_clk period (BLINK_STATS_EN adds wrap_count).
// Latency: led/step update on the edge that consumes a tick; tick trails a divided_clk rise by SYNC_STAGES cycles.
// Backpressure: none; loads are held pending and applied in IDLE, on the arming tick or on the wrap tick.
module blink_sequencer
    import blink_pkg::*;
#(
    parameter int                     SYNC_STAGES = 2,
    parameter int                     PATTERN_LEN = DEFAULT_PATTERN_LEN,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = DEFAULT_PATTERN,
    localparam int                    STEP_W      = $clog2(PATTERN_LEN)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   divided_clk,
    input  logic                   enable,
    input  logic                   load,
    input  logic [PATTERN_LEN-1:0] pattern_in,
    output logic                   led,
    output logic                   tick,
    output logic [STEP_W-1:0]      step,
    output logic                   busy,
    output logic [7:0]             wrap_count
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(PATTERN_LEN - 1);

    blink_state_t           state;
    logic [PATTERN_LEN-1:0] pattern_reg;
    logic [PATTERN_LEN-1:0] pending_pat;
    logic                   pending_valid;

    logic [PATTERN_LEN-1:0] next_pat;
    logic [STEP_W-1:0]      step_inc;
    logic                   at_last;

    edge_sync_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
        .clk  (clk),
        .reset(reset),
        .d    (divided_clk),
        .rise (tick)
    );

    // A load in the same cycle as an applying tick takes effect immediately.
    always_comb begin
        next_pat = pattern_reg;
        if (load) begin
            next_pat = pattern_in;
        end else if (pending_valid) begin
            next_pat = pending_pat;
        end
    end

    assign step_inc = step + 1'b1;
    assign at_last  = (step == LAST_STEP);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            led           <= 1'b0;
            step          <= '0;
            pattern_reg   <= PATTERN;
            pending_pat   <= '0;
            pending_valid <= 1'b0;
        end else begin
            if (load) begin
                pending_pat   <= pattern_in;
                pending_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    led  <= 1'b0;
                    step <= '0;
                    if (pending_valid) begin
                        pattern_reg <= pending_pat;
                        if (!load) begin
                            pending_valid <= 1'b0;
                        end
                    end
                    if (enable) begin
                        state <= ARM;
                    end
                end

                ARM: begin
                    if (!enable) begin
                        state <= IDLE;
                        led   <= 1'b0;
                        step  <= '0;
                    end else if (tick) begin
                        state         <= RUN;
                        step          <= '0;
                        pattern_reg   <= next_pat;
                        pending_valid <= 1'b0;
                        led           <= next_pat[0];
                    end
                end

                RUN: begin
                    if (!enable) begin
                        state <= IDLE;
                        led   <= 1'b0;
                        step  <= '0;
                    end else if (tick) begin
                        if (at_last) begin
                            step          <= '0;
                            pattern_reg   <= next_pat;
                            pending_valid <= 1'b0;
                            led           <= next_pat[0];
                        end else begin
                            step <= step_inc;
                            led  <= pattern_reg[step_inc];
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    led   <= 1'b0;
                    step  <= '0;
                end
            endcase
        end
    end

`ifdef BLINK_STATS_EN
    logic [7:0] wrap_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_q <= 8'd0;
        end else if ((state == RUN) && enable && tick && at_last && (wrap_q != 8'hFF)) begin
            wrap_q <= wrap_q + 8'd1;
        end
    end

    assign wrap_count = wrap_q;
`else
    assign wrap_count = 8'd0;
`endif

endmodule

// File: tb/tb_blink_sequencer.sv
// Randomised and directed stimulus for blink_sequencer, scored against a behavioural model.
module tb_blink_sequencer;

    localparam int         S   = 2;
    localparam int         L   = 8;
    localparam logic [7:0] PAT = 8'b1010_1100;

    logic       clk;
    logic       reset;
    logic       divided_clk;
    logic       enable;
    logic       load;
    logic [7:0] pattern_in;
    logic       led;
    logic       tick;
    logic [2:0] step;
    logic       busy;
    logic [7:0] wrap_count;

    blink_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .divided_clk(divided_clk),
        .enable     (enable),
        .load       (load),
        .pattern_in (pattern_in),
        .led        (led),
        .tick       (tick),
        .step       (step),
        .busy       (busy),
        .wrap_count (wrap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int asserts = 0;
    int fails   = 0;
    int dut_ticks = 0;

    function automatic void chk(input string nm, input int act, input int exp);
        asserts++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        int         cyc;
        logic       tick;
        logic       led;
        logic [2:0] step;
        logic       busy;
        logic [7:0] wc;
    } exp_t;

    exp_t sb[$];
    bit   hist[$];      // divided_clk samples since the last reset, oldest first
    int   m_mode;       // 0 idle, 1 waiting for first tick, 2 playing
    int   m_pos;
    bit   m_led;
    bit   m_tick;
    logic [7:0] m_pat, m_pend;
    bit   m_pend_v;
    int   m_wraps;

    function automatic void model_edge(input logic r, input logic d, input logic e,
                                       input logic l, input logic [7:0] p);
        exp_t       x;
        logic [7:0] np;
        bit         nv, t, consumed;
        int         c;
        consumed = 0;
        if (r) begin
            hist.delete();
            m_tick = 0; m_mode = 0; m_pos = 0; m_led = 0;
            m_pat = PAT; m_pend = 8'h00; m_pend_v = 0; m_wraps = 0;
        end else begin
            t  = m_tick;
            np = l ? p : m_pend;
            nv = l || m_pend_v;
            if (m_mode == 0) begin
                if (m_pend_v) begin m_pat = m_pend; m_pend_v = 0; end
                m_led = 0; m_pos = 0;
                if (e) m_mode = 1;
            end else if (!e) begin
                m_mode = 0; m_led = 0; m_pos = 0;
            end else if (t) begin
                if (m_mode == 1 || m_pos == L - 1) begin
                    if (m_mode == 2 && m_wraps < 255) m_wraps++;
                    if (nv) begin m_pat = np; m_pend_v = 0; consumed = 1; end
                    m_pos = 0; m_mode = 2;
                end else begin
                    m_pos++;
                end
                m_led = m_pat[m_pos];
            end
            if (l && !consumed) begin m_pend = p; m_pend_v = 1; end
            // Rising edge seen S edges late, and only when both samples postdate reset.
            hist.push_back(d);
            c = hist.size();
            m_tick = (c - S >= 1) && hist[c-S] && !hist[c-S-1];
        end
        x.cyc  = cyc + 1;
        x.tick = m_tick;
        x.led  = m_led;
        x.step = 3'(m_pos);
        x.busy = (m_mode != 0);
`ifdef BLINK_STATS_EN
        x.wc   = 8'(m_wraps);
`else
        x.wc   = 8'd0;
`endif
        sb.push_back(x);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t x;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            x = sb.pop_front();
            chk("scoreboard_missed_entry", x.cyc, cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            x = sb.pop_front();
            chk("tick", int'(tick), int'(x.tick));
            chk("led", int'(led), int'(x.led));
            chk("step", int'(step), int'(x.step));
            chk("busy", int'(busy), int'(x.busy));
            chk("wrap_count", int'(wrap_count), int'(x.wc));
        end
        if (tick === 1'b1) dut_ticks++;
    end

    // ---------------- stimulus ----------------
    int dph  = 0;
    int half = 4;

    task automatic drive_d(input logic r, input logic d, input logic e,
                           input logic l, input logic [7:0] p);
        reset = r; divided_clk = d; enable = e; load = l; pattern_in = p;
        model_edge(r, d, e, l, p);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic l, input logic [7:0] p);
        logic d;
        d = ((dph / half) % 2) == 1;
        dph++;
        drive_d(r, d, e, l, p);
    endtask

    task automatic run(input int n, input logic e);
        for (int i = 0; i < n; i++) drive(1'b0, e, 1'b0, 8'h00);
    endtask

    initial begin
        bit         found;
        logic       rd;
        int         exp_wc;
        reset = 1'b1; divided_clk = 1'b0; enable = 1'b0; load = 1'b0; pattern_in = 8'h00;
        @(posedge clk);
        #1;

        // Reset with random inputs.
        for (int i = 0; i < 3; i++)
            drive_d(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
        chk("reset_led", int'(led), 0);
        chk("reset_busy", int'(busy), 0);

        // Basic run, 8-cycle divided clock, three full patterns.
        half = 4; dph = 0;
        run(8 * 8 * 3 + 10, 1'b1);

        // Mid-run load of all ones at step 3.
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (m_mode == 2 && m_pos == 3) found = 1;
            else run(1, 1'b1);
        end
        chk("wait_step3_timeout", int'(found), 1);
        drive(1'b0, 1'b1, 1'b1, 8'hFF);
        run(8 * 10, 1'b1);

        // Load coincident with the wrap tick.
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (m_mode == 2 && m_pos == L - 1 && m_tick) found = 1;
            else run(1, 1'b1);
        end
        chk("wait_wrap_timeout", int'(found), 1);
        drive(1'b0, 1'b1, 1'b1, 8'h0F);
        chk("coincident_load_led", int'(led), 1);
        chk("coincident_load_step", int'(step), 0);
        run(8 * 6, 1'b1);

        // Enable drop on the tick at step 5.
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (m_mode == 2 && m_pos == 5 && m_tick) found = 1;
            else run(1, 1'b1);
        end
        chk("wait_step5_timeout", int'(found), 1);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("drop_led", int'(led), 0);
        chk("drop_step", int'(step), 0);
        chk("drop_busy", int'(busy), 0);
        run(3, 1'b0);
        run(40, 1'b1);

        // divided_clk held high across reset must not produce a tick.
        for (int i = 0; i < 3; i++) drive_d(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) drive_d(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        dut_ticks = 0;
        for (int i = 0; i < 20; i++) drive_d(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("held_high_ticks", dut_ticks, 0);
        for (int i = 0; i < 4; i++) drive_d(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) drive_d(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) drive_d(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("single_rise_ticks", dut_ticks, 1);

        // Random traffic.
        rd = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rd = ~rd;
            drive_d(1'b0, rd, ($urandom_range(0, 24) != 0),
                    ($urandom_range(0, 29) == 0), 8'($urandom));
        end

        // Long run to saturate the wrap counter.
        for (int i = 0; i < 2; i++) drive_d(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        half = 2; dph = 0;
        run(300 * L * 4 + 40, 1'b1);
`ifdef BLINK_STATS_EN
        exp_wc = 255;
`else
        exp_wc = 0;
`endif
        chk("wrap_count_final", int'(wrap_count), exp_wc);

        run(4, 1'b1);
        chk("scoreboard_drained", sb.size() <= 1 ? 1 : 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
